// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Owns the PC, issues one 16-bit instruction
// read at a time to instruction memory, buffers returned words and presents
// {instr, fetch address + 2} to decode over a valid/ready handshake. Execute
// can redirect the PC at any time; fetching stops after a HALT word (opcode
// bits [15:11] == 5'b00000) until a redirect arrives.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   BUF_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   imem_req / imem_addr    registered one-cycle read request and its address
//   imem_valid / imem_data  read data returned by memory
//   redirect / redirect_pc  taken branch/jump from execute; flushes the buffer
//   if_valid / if_ready     handshake with decode for the buffer head
//   if_instr / if_pc_plus2  head instruction and its fetch address + 2
//   halted                  HALT fetched, no further requests
//
// Optional build macro
//   FETCH_PERF_EN  adds perf_fetch_cnt (words pushed) and perf_stall_cnt
//                  (cycles if_valid & !if_ready), both saturating 16-bit.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [4:0] OP_HALT = 5'b00000;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DROP,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic             imem_req_q, imem_req_d;
    logic [15:0]      imem_addr_q, imem_addr_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      buf_instr_q [BUF_DEPTH];
    logic [15:0]      buf_instr_d [BUF_DEPTH];
    logic [15:0]      buf_pcp2_q  [BUF_DEPTH];
    logic [15:0]      buf_pcp2_d  [BUF_DEPTH];

    logic             push;
    logic             pop;
    logic             outstanding;

`ifdef FETCH_PERF_EN
    logic [15:0]      perf_fetch_q, perf_fetch_d;
    logic [15:0]      perf_stall_q, perf_stall_d;
`endif

    assign if_valid    = (count_q != '0);
    assign pop         = if_valid && if_ready;
    // WAIT and DROP both mean a read has been issued and not yet returned.
    assign outstanding = (state_q == S_WAIT) || (state_q == S_DROP);

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign halted      = halted_q;
    assign if_instr    = if_valid ? buf_instr_q[rd_ptr_q] : 16'h0000;
    assign if_pc_plus2 = if_valid ? buf_pcp2_q[rd_ptr_q]  : 16'h0000;

`ifdef FETCH_PERF_EN
    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

    // Next-state logic. A redirect overrides everything else in its cycle:
    // the buffer is flushed and, unless an older read is still in flight,
    // the request for the new target goes out straight away so memory sees
    // it the very next cycle. A read still in flight is parked in DROP so its
    // late data is thrown away.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        halted_d    = halted_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf_instr_d = buf_instr_q;
        buf_pcp2_d  = buf_pcp2_q;
        push        = 1'b0;

        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
            if (outstanding && !imem_valid) begin
                pc_d    = redirect_pc;
                state_d = S_DROP;
            end else begin
                imem_req_d  = 1'b1;
                imem_addr_d = redirect_pc;
                pc_d        = redirect_pc + 16'd2;
                state_d     = S_WAIT;
            end
        end else begin
            unique case (state_q)
                S_RUN: begin
                    // Only RUN issues, so nothing is outstanding here and the
                    // buffer fill alone decides whether there is room.
                    if (count_q < DEPTH_C) begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_q;
                        pc_d        = pc_q + 16'd2;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        push = 1'b1;
                        if (imem_data[15:11] == OP_HALT) begin
                            state_d  = S_HALTED;
                            halted_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_valid) begin
                        state_d = S_RUN;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase

            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_data;
                buf_pcp2_d[wr_ptr_q]  = imem_addr_q + 16'd2;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters; a redirect does not clear them.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (push && (perf_fetch_q != 16'hFFFF)) begin
            perf_fetch_d = perf_fetch_q + 16'd1;
        end
        if (if_valid && !if_ready && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= 16'h0000;
            perf_stall_q <= 16'h0000;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 16'h0000;
            halted_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= 16'h0000;
                buf_pcp2_q[i]  <= 16'h0000;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            halted_q    <= halted_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_instr_q <= buf_instr_d;
            buf_pcp2_q  <= buf_pcp2_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage (BUF_DEPTH=2, RESET_PC=0). A small
// instruction-memory responder inside the tick task answers each request
// after mem_lat cycles with mem_word(addr) = addr ^ 16'hC005 (opcode never
// zero for the addresses used), or 16'h0000 (HALT) at halt_addr when enabled.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Memory responder state.
    logic        mem_pending = 1'b0;
    logic [15:0] mem_addr    = 16'h0000;
    int          mem_wait    = 0;
    int          mem_lat     = 1;
    logic        halt_en     = 1'b0;
    logic [15:0] halt_addr   = 16'h0001;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc_plus2(if_pc_plus2),
        .halted     (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_en && (a == halt_addr)) begin
            return 16'h0000;
        end
        return a ^ 16'hC005;
    endfunction

    // Advance one clock; 1 time unit after the edge drive memory responses
    // and latch any new request seen on the DUT outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        if (mem_pending) begin
            if (mem_wait == 0) begin
                imem_valid  = 1'b1;
                imem_data   = mem_word(mem_addr);
                mem_pending = 1'b0;
            end else begin
                mem_wait = mem_wait - 1;
            end
        end
        if (imem_req) begin
            mem_pending = 1'b1;
            mem_addr    = imem_addr;
            mem_wait    = mem_lat - 1;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        mem_pending = 1'b0;
        imem_valid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        if_ready    = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_valid); end
        checks++; if (if_instr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0000", if_instr); end
        checks++; if (if_pc_plus2 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pcp2: got %h expected 0000", if_pc_plus2); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_basic();
        logic [15:0] reqs[$];
        int          first_req   = -1;
        int          first_valid = -1;
        logic [15:0] fv_instr    = 16'hxxxx;
        logic [15:0] fv_pc       = 16'hxxxx;
        mem_lat  = 1;
        if_ready = 1'b1;
        rst_n    = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (imem_req) begin
                reqs.push_back(imem_addr);
                if (first_req < 0) first_req = cyc;
            end
            if (if_valid && (first_valid < 0)) begin
                first_valid = cyc;
                fv_instr    = if_instr;
                fv_pc       = if_pc_plus2;
            end
        end
        checks++; if (reqs.size() < 3) begin errors++; $display("[TB] FAIL basic_req_count: got %0d expected >=3", reqs.size()); end
        checks++; if ((reqs.size() > 0 ? reqs[0] : 16'hxxxx) !== 16'h0000) begin errors++; $display("[TB] FAIL basic_req0: got %h expected 0000", reqs.size() > 0 ? reqs[0] : 16'hxxxx); end
        checks++; if ((reqs.size() > 1 ? reqs[1] : 16'hxxxx) !== 16'h0002) begin errors++; $display("[TB] FAIL basic_req1: got %h expected 0002", reqs.size() > 1 ? reqs[1] : 16'hxxxx); end
        checks++; if ((reqs.size() > 2 ? reqs[2] : 16'hxxxx) !== 16'h0004) begin errors++; $display("[TB] FAIL basic_req2: got %h expected 0004", reqs.size() > 2 ? reqs[2] : 16'hxxxx); end
        checks++; if ((first_valid - first_req) !== 2) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 2", first_valid - first_req); end
        checks++; if (fv_instr !== 16'hC005) begin errors++; $display("[TB] FAIL basic_instr: got %h expected C005", fv_instr); end
        checks++; if (fv_pc !== 16'h0002) begin errors++; $display("[TB] FAIL basic_pcp2: got %h expected 0002", fv_pc); end
    endtask

    task automatic test_backpressure();
        logic [15:0] reqs[$];
        logic [31:0] pops[$];
        logic        seen     = 1'b0;
        logic        unstable = 1'b0;
        logic [31:0] head     = 32'h0;
        if_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (cyc == 0) redirect = 1'b0;
            if (imem_req) reqs.push_back(imem_addr);
            if (if_valid) begin
                if (seen && ({if_instr, if_pc_plus2} != head)) unstable = 1'b1;
                seen = 1'b1;
                head = {if_instr, if_pc_plus2};
            end
        end
        checks++; if (reqs.size() !== 2) begin errors++; $display("[TB] FAIL bp_req_count: got %0d expected 2", reqs.size()); end
        checks++; if ((reqs.size() > 0 ? reqs[0] : 16'hxxxx) !== 16'h0200) begin errors++; $display("[TB] FAIL bp_req0: got %h expected 0200", reqs.size() > 0 ? reqs[0] : 16'hxxxx); end
        checks++; if ((reqs.size() > 1 ? reqs[1] : 16'hxxxx) !== 16'h0202) begin errors++; $display("[TB] FAIL bp_req1: got %h expected 0202", reqs.size() > 1 ? reqs[1] : 16'hxxxx); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", if_valid); end
        checks++; if (if_instr !== 16'hC205) begin errors++; $display("[TB] FAIL bp_head_instr: got %h expected C205", if_instr); end
        checks++; if (if_pc_plus2 !== 16'h0202) begin errors++; $display("[TB] FAIL bp_head_pcp2: got %h expected 0202", if_pc_plus2); end
        checks++; if (unstable !== 1'b0) begin errors++; $display("[TB] FAIL bp_head_stable: got %b expected 0", unstable); end
        if_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (if_valid) pops.push_back({if_instr, if_pc_plus2});
            tick();
        end
        checks++; if ((pops.size() > 0 ? pops[0] : 32'hxxxxxxxx) !== 32'hC205_0202) begin errors++; $display("[TB] FAIL bp_drain0: got %h expected C2050202", pops.size() > 0 ? pops[0] : 32'hxxxxxxxx); end
        checks++; if ((pops.size() > 1 ? pops[1] : 32'hxxxxxxxx) !== 32'hC207_0204) begin errors++; $display("[TB] FAIL bp_drain1: got %h expected C2070204", pops.size() > 1 ? pops[1] : 32'hxxxxxxxx); end
        checks++; if ((pops.size() > 2 ? pops[2] : 32'hxxxxxxxx) !== 32'hC201_0206) begin errors++; $display("[TB] FAIL bp_drain2: got %h expected C2010206", pops.size() > 2 ? pops[2] : 32'hxxxxxxxx); end
    endtask

    task automatic test_redirect_drop();
        logic        found     = 1'b0;
        logic [15:0] first_req = 16'hxxxx;
        logic [31:0] first_pop = 32'hxxxxxxxx;
        logic        got_req   = 1'b0;
        logic        got_pop   = 1'b0;
        logic        saw_stale = 1'b0;
        mem_lat  = 3;
        if_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && (imem_addr == 16'h0004)) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL drop_wait_req0004: got %b expected 1", found); end
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_flush_valid: got %b expected 0", if_valid); end
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (imem_req && !got_req) begin got_req = 1'b1; first_req = imem_addr; end
            if (if_valid && !got_pop) begin got_pop = 1'b1; first_pop = {if_instr, if_pc_plus2}; end
            if (if_valid && (if_pc_plus2 == 16'h0006)) saw_stale = 1'b1;
            tick();
        end
        checks++; if (first_req !== 16'h0100) begin errors++; $display("[TB] FAIL drop_next_req: got %h expected 0100", first_req); end
        checks++; if (first_pop !== 32'hC105_0102) begin errors++; $display("[TB] FAIL drop_first_head: got %h expected C1050102", first_pop); end
        checks++; if (saw_stale !== 1'b0) begin errors++; $display("[TB] FAIL drop_stale_word: got %b expected 0", saw_stale); end
    endtask

    task automatic test_halt();
        logic [15:0] reqs[$];
        logic [31:0] pops[$];
        mem_lat     = 1;
        halt_en     = 1'b1;
        halt_addr   = 16'h0010;
        if_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h000C;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (cyc == 0) redirect = 1'b0;
            if (imem_req) reqs.push_back(imem_addr);
            if (if_valid) pops.push_back({if_instr, if_pc_plus2});
        end
        checks++; if (reqs.size() !== 3) begin errors++; $display("[TB] FAIL halt_req_count: got %0d expected 3", reqs.size()); end
        checks++; if ((reqs.size() > 0 ? reqs[0] : 16'hxxxx) !== 16'h000C) begin errors++; $display("[TB] FAIL halt_req0: got %h expected 000C", reqs.size() > 0 ? reqs[0] : 16'hxxxx); end
        checks++; if ((reqs.size() > 2 ? reqs[2] : 16'hxxxx) !== 16'h0010) begin errors++; $display("[TB] FAIL halt_req2: got %h expected 0010", reqs.size() > 2 ? reqs[2] : 16'hxxxx); end
        checks++; if (pops.size() !== 3) begin errors++; $display("[TB] FAIL halt_pop_count: got %0d expected 3", pops.size()); end
        checks++; if ((pops.size() > 0 ? pops[pops.size()-1] : 32'hxxxxxxxx) !== 32'h0000_0012) begin errors++; $display("[TB] FAIL halt_word: got %h expected 00000012", pops.size() > 0 ? pops[pops.size()-1] : 32'hxxxxxxxx); end
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %b expected 1", halted); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_drained: got %b expected 0", if_valid); end
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_clear: got %b expected 0", halted); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL halt_resume_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 16'h0020) begin errors++; $display("[TB] FAIL halt_resume_addr: got %h expected 0020", imem_addr); end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] reqs[$];
        logic [31:0] pops[$];
        if_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (cyc == 0) redirect = 1'b0;
            if (imem_req) reqs.push_back(imem_addr);
            if (if_valid) pops.push_back({if_instr, if_pc_plus2});
        end
        checks++; if ((reqs.size() > 0 ? reqs[0] : 16'hxxxx) !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_req0: got %h expected FFFE", reqs.size() > 0 ? reqs[0] : 16'hxxxx); end
        checks++; if ((reqs.size() > 1 ? reqs[1] : 16'hxxxx) !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_req1: got %h expected 0000", reqs.size() > 1 ? reqs[1] : 16'hxxxx); end
        checks++; if ((pops.size() > 0 ? pops[0] : 32'hxxxxxxxx) !== 32'h3FFB_0000) begin errors++; $display("[TB] FAIL wrap_head0: got %h expected 3FFB0000", pops.size() > 0 ? pops[0] : 32'hxxxxxxxx); end
        checks++; if ((pops.size() > 1 ? pops[1] : 32'hxxxxxxxx) !== 32'hC005_0002) begin errors++; $display("[TB] FAIL wrap_head1: got %h expected C0050002", pops.size() > 1 ? pops[1] : 32'hxxxxxxxx); end
    endtask

    task automatic test_reset_mid();
        logic        found     = 1'b0;
        logic [15:0] first_req = 16'hxxxx;
        logic [31:0] first_pop = 32'hxxxxxxxx;
        logic        got_req   = 1'b0;
        logic        got_pop   = 1'b0;
        logic        saw_stale = 1'b0;
        mem_lat     = 3;
        if_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            redirect = 1'b0;
            if (imem_req && (imem_addr == 16'h0300)) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL mid_wait_req0300: got %b expected 1", found); end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_req: got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", if_valid); end
        checks++; if (if_instr !== 16'h0000) begin errors++; $display("[TB] FAIL mid_instr: got %h expected 0000", if_instr); end
        checks++; if (if_pc_plus2 !== 16'h0000) begin errors++; $display("[TB] FAIL mid_pcp2: got %h expected 0000", if_pc_plus2); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL mid_halted: got %b expected 0", halted); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (imem_req && !got_req) begin got_req = 1'b1; first_req = imem_addr; end
            if (if_valid && !got_pop) begin got_pop = 1'b1; first_pop = {if_instr, if_pc_plus2}; end
            if (if_valid && (if_pc_plus2 == 16'h0302)) saw_stale = 1'b1;
        end
        checks++; if (first_req !== 16'h0000) begin errors++; $display("[TB] FAIL mid_first_req: got %h expected 0000", first_req); end
        checks++; if (first_pop !== 32'hC005_0002) begin errors++; $display("[TB] FAIL mid_first_head: got %h expected C0050002", first_pop); end
        checks++; if (saw_stale !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_word: got %b expected 0", saw_stale); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_drop();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
